// File: rtl/regbank_wb_arb.sv
// Two-requester (ALU / load) writeback arbiter for an 8 x 8-bit register bank write port.
// Build option: define REGBANK_WB_ARB_RR_EN for round-robin arbitration; otherwise ALU wins contention.
module regbank_wb_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       alu_valid_i,
  input  logic [2:0] alu_rd_i,
  input  logic [7:0] alu_dat_i,
  output logic       alu_ready_o,
  input  logic       mem_valid_i,
  input  logic [2:0] mem_rd_i,
  input  logic [7:0] mem_dat_i,
  output logic       mem_ready_o,
  output logic       we_o,
  output logic [2:0] rd_o,
  output logic [7:0] dat_o,
  output logic [7:0] busy_o,
  output logic       conflict_o
);

  typedef enum logic {
    PRI_ALU = 1'b0,
    PRI_MEM = 1'b1
  } arb_state_t;

  arb_state_t state_reg;
  arb_state_t state_next;

  // Slot index 0 is the ALU requester, index 1 is the load requester.
  logic [1:0] req_valid;
  logic [2:0] req_rd   [2];
  logic [7:0] req_dat  [2];
  logic [1:0] slot_full;
  logic [1:0] slot_age;
  logic [2:0] slot_rd  [2];
  logic [7:0] slot_dat [2];
  logic [1:0] grant;
  logic [1:0] ready;
  logic [1:0] accept;
  logic [2:0] sel_rd;
  logic [7:0] sel_dat;

  assign req_valid  = {mem_valid_i, alu_valid_i};
  assign req_rd[0]  = alu_rd_i;
  assign req_rd[1]  = mem_rd_i;
  assign req_dat[0] = alu_dat_i;
  assign req_dat[1] = mem_dat_i;

  assign alu_ready_o = ready[0];
  assign mem_ready_o = ready[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      localparam int OTHER = 1 - gi;

      logic       full_reg;
      logic       age_reg;
      logic [2:0] rd_reg;
      logic [7:0] dat_reg;

      // A slot can take a new request in the same cycle its current one is granted.
      assign ready[gi]  = cen & rst & (~full_reg | grant[gi]);
      assign accept[gi] = req_valid[gi] & ready[gi];

      // age_reg set means this slot's entry was accepted before the other slot's entry.
      always_ff @(posedge clk) begin
        if (!rst) begin
          full_reg <= 1'b0;
          age_reg  <= 1'b0;
          rd_reg   <= 3'd0;
          dat_reg  <= 8'h00;
        end else if (cen) begin
          if (accept[gi]) begin
            full_reg <= 1'b1;
            age_reg  <= 1'b0;
            rd_reg   <= req_rd[gi];
            dat_reg  <= req_dat[gi];
          end else begin
            if (grant[gi]) begin
              full_reg <= 1'b0;
            end
            if (accept[OTHER]) begin
              age_reg <= 1'b1;
            end
          end
        end
      end

      assign slot_full[gi] = full_reg;
      assign slot_age[gi]  = age_reg;
      assign slot_rd[gi]   = rd_reg;
      assign slot_dat[gi]  = dat_reg;
    end
  endgenerate

  // Arbiter state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= PRI_ALU;
    end else if (cen) begin
      state_reg <= state_next;
    end
  end

  // Arbiter next state: the priority pointer moves away from whoever was just served.
  always_comb begin
    state_next = state_reg;
`ifdef REGBANK_WB_ARB_RR_EN
    if (grant[0]) begin
      state_next = PRI_MEM;
    end else if (grant[1]) begin
      state_next = PRI_ALU;
    end
`else
    state_next = PRI_ALU;
`endif
  end

  // Arbiter outputs: same destination forces oldest-first so writes to one register stay ordered.
  always_comb begin
    grant = 2'b00;
    if (cen && rst) begin
      if (slot_full[0] && slot_full[1]) begin
        if (slot_rd[0] == slot_rd[1]) begin
          if (slot_age[0] && !slot_age[1]) begin
            grant = 2'b01;
          end else begin
            grant = 2'b10;
          end
        end else if (state_reg == PRI_ALU) begin
          grant = 2'b01;
        end else begin
          grant = 2'b10;
        end
      end else if (slot_full[0]) begin
        grant = 2'b01;
      end else if (slot_full[1]) begin
        grant = 2'b10;
      end
    end
  end

  assign sel_rd  = grant[1] ? slot_rd[1]  : slot_rd[0];
  assign sel_dat = grant[1] ? slot_dat[1] : slot_dat[0];

  // Register-bank write stage; a grant for r0 is consumed without a write strobe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      we_o       <= 1'b0;
      rd_o       <= 3'd0;
      dat_o      <= 8'h00;
      conflict_o <= 1'b0;
    end else begin
      conflict_o <= cen & slot_full[0] & slot_full[1];
      if (cen && (grant != 2'b00)) begin
        we_o  <= (sel_rd != 3'd0);
        rd_o  <= sel_rd;
        dat_o <= sel_dat;
      end else begin
        we_o <= 1'b0;
      end
    end
  end

  always_comb begin
    busy_o = 8'h00;
    for (int i = 0; i < 2; i++) begin
      if (slot_full[i]) begin
        busy_o[slot_rd[i]] = 1'b1;
      end
    end
    if (we_o) begin
      busy_o[rd_o] = 1'b1;
    end
    busy_o[0] = 1'b0;
  end

endmodule

// File: tb/tb_regbank_wb_arb.sv
// Self-checking bench for regbank_wb_arb: directed vector table, corner sequences, random run vs model.
module tb_regbank_wb_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic       cen;
  logic       alu_valid_i;
  logic [2:0] alu_rd_i;
  logic [7:0] alu_dat_i;
  logic       alu_ready_o;
  logic       mem_valid_i;
  logic [2:0] mem_rd_i;
  logic [7:0] mem_dat_i;
  logic       mem_ready_o;
  logic       we_o;
  logic [2:0] rd_o;
  logic [7:0] dat_o;
  logic [7:0] busy_o;
  logic       conflict_o;

  always #5 clk = ~clk;

  regbank_wb_arb dut (
    .clk         (clk),
    .rst         (rst),
    .cen         (cen),
    .alu_valid_i (alu_valid_i),
    .alu_rd_i    (alu_rd_i),
    .alu_dat_i   (alu_dat_i),
    .alu_ready_o (alu_ready_o),
    .mem_valid_i (mem_valid_i),
    .mem_rd_i    (mem_rd_i),
    .mem_dat_i   (mem_dat_i),
    .mem_ready_o (mem_ready_o),
    .we_o        (we_o),
    .rd_o        (rd_o),
    .dat_o       (dat_o),
    .busy_o      (busy_o),
    .conflict_o  (conflict_o)
  );

`ifdef REGBANK_WB_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Reference model: pending requests carry their acceptance time; last_alu remembers who was served last.
  bit       a_full, m_full;
  bit [2:0] a_rd, m_rd;
  bit [7:0] a_dat, m_dat;
  int       a_t, m_t;
  bit       last_alu;
  bit       o_we, o_conf;
  bit [2:0] o_rd;
  bit [7:0] o_dat;
  int       cyc = 0;

  logic [10:0] wlog[$];
  logic [7:0]  bank[8];

  function automatic int winner();
    if (rst == 1'b0 || cen == 1'b0) return 0;
    if (a_full && m_full) begin
      if (a_rd == m_rd) return (a_t < m_t) ? 1 : 2;
      if (!RR) return 1;
      return last_alu ? 2 : 1;
    end
    if (a_full) return 1;
    if (m_full) return 2;
    return 0;
  endfunction

  task automatic model_check(input string tag);
    int w;
    bit ar, mr;
    bit [7:0] b;
    w  = winner();
    ar = (rst == 1'b1) && (cen == 1'b1) && (!a_full || w == 1);
    mr = (rst == 1'b1) && (cen == 1'b1) && (!m_full || w == 2);
    b  = 8'h00;
    if (a_full) b[a_rd] = 1'b1;
    if (m_full) b[m_rd] = 1'b1;
    if (o_we)   b[o_rd] = 1'b1;
    b[0] = 1'b0;
    chk({tag, "_alu_ready"}, alu_ready_o, ar);
    chk({tag, "_mem_ready"}, mem_ready_o, mr);
    chk({tag, "_we"}, we_o, o_we);
    chk({tag, "_busy"}, busy_o, b);
    chk({tag, "_conflict"}, conflict_o, o_conf);
    if (o_we) begin
      chk({tag, "_rd"}, rd_o, o_rd);
      chk({tag, "_dat"}, dat_o, o_dat);
    end
  endtask

  task automatic model_step();
    int w;
    bit ar, mr;
    w  = winner();
    ar = (rst == 1'b1) && (cen == 1'b1) && (!a_full || w == 1);
    mr = (rst == 1'b1) && (cen == 1'b1) && (!m_full || w == 2);
    if (rst == 1'b0) begin
      a_full = 0; m_full = 0; o_we = 0; o_rd = 0; o_dat = 0; o_conf = 0; last_alu = 0;
    end else if (cen == 1'b0) begin
      o_we = 0; o_conf = 0;
    end else begin
      o_conf = a_full && m_full;
      if (w == 1) begin
        o_rd = a_rd; o_dat = a_dat; o_we = (a_rd != 0); a_full = 0; last_alu = 1;
      end else if (w == 2) begin
        o_rd = m_rd; o_dat = m_dat; o_we = (m_rd != 0); m_full = 0; last_alu = 0;
      end else begin
        o_we = 0;
      end
      if (alu_valid_i && ar) begin a_full = 1; a_rd = alu_rd_i; a_dat = alu_dat_i; a_t = cyc; end
      if (mem_valid_i && mr) begin m_full = 1; m_rd = mem_rd_i; m_dat = mem_dat_i; m_t = cyc; end
    end
    cyc++;
  endtask

  task automatic drive(input bit r, input bit c, input bit av, input bit [2:0] ard, input bit [7:0] adat,
                       input bit mv, input bit [2:0] mrd, input bit [7:0] mdat);
    rst = r; cen = c;
    alu_valid_i = av; alu_rd_i = ard; alu_dat_i = adat;
    mem_valid_i = mv; mem_rd_i = mrd; mem_dat_i = mdat;
  endtask

  task automatic idle();
    drive(1, 1, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
  endtask

  // One clock: optional model comparison at the falling edge, then advance model and DUT together.
  task automatic cycle(input bit do_check, input string tag);
    @(negedge clk);
    if (do_check) model_check(tag);
    if (we_o === 1'b1) begin
      bank[rd_o] = dat_o;
      wlog.push_back({rd_o, dat_o});
      $display("write r%0d <= %02h (%s)", rd_o, dat_o, tag);
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 1, 1, 3'd5, 8'h99, 1, 3'd6, 8'h66);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_alu_ready", alu_ready_o, 0);
      chk("rst_mem_ready", mem_ready_o, 0);
      model_step();
      @(posedge clk);
      #1;
    end
    idle();
    @(negedge clk);
    chk("rst_we", we_o, 0);
    chk("rst_rd", rd_o, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_conflict", conflict_o, 0);
    chk("rst_busy", busy_o, 0);
    $display("reset checked");
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit       cen;
    bit       av;
    bit [2:0] ard;
    bit [7:0] adat;
    bit       mv;
    bit [2:0] mrd;
    bit [7:0] mdat;
    bit       e_ar;
    bit       e_mr;
    bit       e_we;
    bit [2:0] e_rd;
    bit [7:0] e_dat;
    bit [7:0] e_busy;
    bit       e_conf;
  } vec_t;

  vec_t tv[12];

  initial begin
    //        cen av ard  adat   mv mrd  mdat   ar mr we rd   dat    busy   conf
    tv[0]  = '{1, 1, 3'd1, 8'h11, 1, 3'd2, 8'h22, 1, 1, 0, 3'd0, 8'h00, 8'h00, 0};
    tv[1]  = '{1, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 1, 0, 0, 3'd0, 8'h00, 8'h06, 0};
    tv[2]  = '{1, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 1, 1, 1, 3'd1, 8'h11, 8'h06, 1};
    tv[3]  = '{1, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 1, 1, 1, 3'd2, 8'h22, 8'h04, 0};
    tv[4]  = '{1, 1, 3'd3, 8'h5A, 0, 3'd0, 8'h00, 1, 1, 0, 3'd0, 8'h00, 8'h00, 0};
    tv[5]  = '{1, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 1, 1, 0, 3'd0, 8'h00, 8'h08, 0};
    tv[6]  = '{1, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 1, 1, 1, 3'd3, 8'h5A, 8'h08, 0};
    tv[7]  = '{1, 1, 3'd0, 8'hFF, 0, 3'd0, 8'h00, 1, 1, 0, 3'd0, 8'h00, 8'h00, 0};
    tv[8]  = '{1, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 1, 1, 0, 3'd0, 8'h00, 8'h00, 0};
    tv[9]  = '{1, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 1, 1, 0, 3'd0, 8'h00, 8'h00, 0};
    tv[10] = '{0, 1, 3'd6, 8'h01, 1, 3'd7, 8'h02, 0, 0, 0, 3'd0, 8'h00, 8'h00, 0};
    tv[11] = '{1, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 1, 1, 0, 3'd0, 8'h00, 8'h00, 0};

    for (int i = 0; i < 8; i++) bank[i] = 8'h00;
    do_reset();

    // Directed vector table: dual accept, single write latency, r0 discard, cen low.
    for (int i = 0; i < 12; i++) begin
      drive(1, tv[i].cen, tv[i].av, tv[i].ard, tv[i].adat, tv[i].mv, tv[i].mrd, tv[i].mdat);
      @(negedge clk);
      chk($sformatf("t%0d_alu_ready", i), alu_ready_o, tv[i].e_ar);
      chk($sformatf("t%0d_mem_ready", i), mem_ready_o, tv[i].e_mr);
      chk($sformatf("t%0d_we", i), we_o, tv[i].e_we);
      chk($sformatf("t%0d_busy", i), busy_o, tv[i].e_busy);
      chk($sformatf("t%0d_conflict", i), conflict_o, tv[i].e_conf);
      if (tv[i].e_we) begin
        chk($sformatf("t%0d_rd", i), rd_o, tv[i].e_rd);
        chk($sformatf("t%0d_dat", i), dat_o, tv[i].e_dat);
      end
      $display("vector %0d: we=%0b rd=%0d dat=%02h busy=%02h", i, we_o, rd_o, dat_o, busy_o);
      model_step();
      @(posedge clk);
      #1;
    end

    // Same-register race: MEM r4 accepted one edge before ALU r4 must be written first.
    do_reset();
    wlog.delete();
    drive(1, 1, 1, 3'd5, 8'h55, 1, 3'd4, 8'hAA);
    cycle(1, "race");
    drive(1, 1, 1, 3'd4, 8'hBB, 0, 3'd0, 8'h00);
    cycle(1, "race");
    idle();
    for (int i = 0; i < 4; i++) cycle(1, "race");
    chk("race_nwrites", wlog.size(), 3);
    if (wlog.size() == 3) begin
      chk("race_w0", wlog[0], {3'd5, 8'h55});
      chk("race_w1", wlog[1], {3'd4, 8'hAA});
      chk("race_w2", wlog[2], {3'd4, 8'hBB});
    end
    chk("race_r4", bank[4], 8'hBB);

    // Clock enable low for three cycles with both slots holding requests.
    wlog.delete();
    drive(1, 1, 1, 3'd1, 8'h10, 1, 3'd2, 8'h20);
    cycle(1, "cen");
    drive(1, 0, 1, 3'd3, 8'h33, 1, 3'd5, 8'h55);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("cen_alu_ready", alu_ready_o, 0);
      chk("cen_mem_ready", mem_ready_o, 0);
      chk("cen_busy", busy_o, 8'h06);
      @(posedge clk);
      #1;
      cycle(1, "cen");
    end
    idle();
    for (int i = 0; i < 4; i++) cycle(1, "cen");
    chk("cen_drain_writes", wlog.size(), 2);

    // Reset while both slots are full: nothing may be written afterwards.
    drive(1, 1, 1, 3'd3, 8'h33, 1, 3'd5, 8'h55);
    cycle(1, "rstfull");
    drive(0, 1, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
    cycle(1, "rstfull");
    idle();
    wlog.delete();
    for (int i = 0; i < 4; i++) cycle(1, "rstfull");
    chk("rstfull_writes", wlog.size(), 0);
    chk("rstfull_busy", busy_o, 8'h00);
    drive(1, 1, 1, 3'd6, 8'h66, 1, 3'd7, 8'h77);
    cycle(1, "rstfull");
    idle();
    for (int i = 0; i < 4; i++) cycle(1, "rstfull");
    chk("rstfull_nwrites", wlog.size(), 2);
    if (wlog.size() == 2) chk("rstfull_alu_first", wlog[0], {3'd6, 8'h66});

    // Random traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 99) != 0, $urandom_range(0, 9) != 0,
            $urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), 8'($urandom),
            $urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), 8'($urandom));
      cycle(1, $sformatf("rnd%0d", i));
    end
    idle();
    for (int i = 0; i < 6; i++) cycle(1, "drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regbank_wb_arb.md
REGBANK_WB_ARB -- requirements
Module: regbank_wb_arb

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  in  1  synchronous, active-low reset.
REQ-003 SHALL have port cen  in  1  clock enable; same meaning as the register bank's cen.
REQ-004 SHALL have ports alu_valid_i in 1, alu_rd_i in 3, alu_dat_i in 8  ALU writeback request (dest reg, data).
REQ-005 SHALL have port alu_ready_o  out  1  ALU request accepted when alu_valid_i & alu_ready_o at a rising edge.
REQ-006 SHALL have ports mem_valid_i in 1, mem_rd_i in 3, mem_dat_i in 8  load writeback request.
REQ-007 SHALL have port mem_ready_o  out  1  load request handshake, same rule as REQ-005.
REQ-008 SHALL have ports we_o out 1, rd_o out 3, dat_o out 8  registered drive of the register bank write port.
REQ-009 SHALL have port busy_o  out  8  bit r set while a write to register r is pending anywhere in this block.
REQ-010 SHALL have port conflict_o  out  1  registered one-cycle pulse: both slots competed for one grant.

Function
REQ-011 SHALL hold one holding slot per requester (rd, dat, full flag, age bit).
REQ-012 SHALL drive x_ready_o = cen & (~slot_full | slot granted this cycle); full-rate 1 request/cycle/requester when uncontested.
REQ-013 SHALL grant at most one full slot per cen cycle; granted slot loads rd_o/dat_o, asserts we_o next cycle, slot empties unless refilled same edge.
REQ-014 SHALL give latency: uncontested request accepted at edge E -> we_o high in the cycle after edge E+1 -> bank written at edge E+2.
REQ-015 SHALL de-assert we_o in any cycle following an edge with no grant; rd_o/dat_o hold last values.
REQ-016 SHALL implement arbiter FSM with states PRI_ALU and PRI_MEM (priority pointer); after granting ALU -> PRI_MEM, after granting MEM -> PRI_ALU; no grant -> hold.
REQ-017 SHALL, when both slots full with the same rd, grant the older slot first (age bit); equal age -> MEM first; pointer then updates per REQ-016.
REQ-018 SHALL pulse conflict_o for one cycle after every edge at which both slots were full and cen high.
REQ-019 SHALL treat rd = 0 as discard: handshake completes, slot consumes a grant, but we_o stays 0 for it and busy_o[0] is never set.
REQ-020 SHALL compute busy_o combinationally as OR over full slots and the output stage (when we_o=1) of one-hot(rd), bit 0 forced 0.
REQ-021 SHALL, with cen low, drive both ready outputs 0, perform no accept/grant, hold FSM, slots and age, and drive we_o 0 in the next cycle.
REQ-022 SHALL never assert we_o for two different requests in one cycle and never lose or duplicate an accepted request.

Reset
REQ-023 SHALL on rst low at a rising edge: both slots empty, we_o=0, rd_o=0, dat_o=0, conflict_o=0, FSM=PRI_ALU.
REQ-024 SHALL discard in-flight slot contents on reset mid-operation; no write issued for them after reset releases.
REQ-025 SHALL drive both ready outputs 0 while rst is low; busy_o reads 0 the cycle after reset.

Configuration
REQ-026 SHALL honour macro REGBANK_WB_ARB_RR_EN: defined -> round-robin per REQ-016; undefined -> fixed priority, ALU always wins contention (FSM held in PRI_ALU), REQ-017 same-rd ordering still applies.

Verification
REQ-027 SHALL cover: ALU rd=3 dat=0x5A accepted alone at edge E -> we_o=1, rd_o=3, dat_o=0x5A after E+1; busy_o=0x08 until write issued.
REQ-028 SHALL cover: ALU rd=1 dat=0x11 and MEM rd=2 dat=0x22 accepted same edge, RR_EN defined, FSM=PRI_ALU -> ALU written first then MEM, conflict_o one pulse.
REQ-029 SHALL cover: same-rd race, MEM rd=4 dat=0xAA accepted one edge before ALU rd=4 dat=0xBB -> writes in order 0xAA, 0xBB; final r4=0xBB.
REQ-030 SHALL cover: ALU rd=0 dat=0xFF -> alu_ready_o handshake completes, we_o never 1, busy_o stays 0.
REQ-031 SHALL cover: cen low 3 cycles with both slots full -> ready 0, we_o 0, no state change; after cen high both drain in 2 grants.
REQ-032 SHALL cover: rst low while both slots full -> no we_o after release; busy_o=0x00; FSM=PRI_ALU.
